// File: rtl/nf10_rx_pkt_queue.sv
// nf10_rx_pkt_queue: store-and-forward rx queue stamping byte length and source port into tuser; NF10_RX_QUEUE_STATS_EN adds packet/drop counters
module nf10_rx_pkt_queue #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2 = 9,
  parameter int C_META_DEPTH_LOG2 = 5,
  parameter logic [7:0] C_SRC_PORT = 8'h01
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
`ifdef NF10_RX_QUEUE_STATS_EN
  ,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     drop_count
`endif
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int TW = C_AXIS_TUSER_WIDTH;
  localparam int AW = C_DEPTH_LOG2;
  localparam int MA = C_META_DEPTH_LOG2;
  localparam int WW = DW + SW + 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(2 ** AW);
  localparam logic [MA:0] MDEPTH = (MA+1)'(2 ** MA);
  localparam logic [AW:0] P_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wstate_t;
  typedef enum logic {R_HEAD, R_BODY} rstate_t;

  logic [WW-1:0] mem [2**AW];
  logic [15:0]   meta_mem [2**MA];

  wstate_t       wstate_q, wstate_d;
  rstate_t       rstate_q, rstate_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, rd_ptr_d, occ;
  logic [MA:0]   meta_wr_q, meta_rd_q, meta_rd_d, meta_pop_q;
  logic [15:0]   len_acc_q, len_acc_d, pop_cnt, len_new;
  logic [16:0]   len_sum;
  logic          buf_full, meta_full, mem_we, meta_push, drop;
  logic [WW-1:0] rd_word;
  logic          can_load, advance;
  logic [TW-1:0] head_user;
  logic [DW-1:0] tdata_q, tdata_d;
  logic [SW-1:0] tstrb_q, tstrb_d;
  logic [TW-1:0] tuser_q, tuser_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic          unused_ok;

  assign unused_ok = ^{s_axis_tuser, drop};
  assign s_axis_tready = ~axi_reset;

  // Byte count of the incoming word.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < SW; i++) pop_cnt = pop_cnt + 16'(s_axis_tstrb[i]);
  end

  // Occupancy counts uncommitted words too, so an oversized packet can never evict committed data.
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign buf_full  = occ == DEPTH;
  assign meta_full = (meta_wr_q - meta_pop_q) == MDEPTH;
  assign len_sum   = {1'b0, len_acc_q} + {1'b0, pop_cnt};
  assign len_new   = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  // Write FSM: len_acc is kept at zero outside a packet so the first word needs no special case.
  always_comb begin
    wstate_d  = wstate_q;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = commit_q;
    len_acc_d = len_acc_q;
    mem_we    = 1'b0;
    meta_push = 1'b0;
    drop      = 1'b0;
    if (s_axis_tvalid && wstate_q != W_DROP) begin
      if ((wstate_q == W_IDLE && meta_full) || buf_full) begin
        drop      = 1'b1;
        wr_ptr_d  = commit_q;
        len_acc_d = '0;
        wstate_d  = s_axis_tlast ? W_IDLE : W_DROP;
      end else begin
        mem_we    = 1'b1;
        wr_ptr_d  = wr_ptr_q + P_ONE;
        len_acc_d = s_axis_tlast ? 16'd0 : len_new;
        commit_d  = s_axis_tlast ? wr_ptr_q + P_ONE : commit_q;
        meta_push = s_axis_tlast;
        wstate_d  = s_axis_tlast ? W_IDLE : W_WRITE;
      end
    end else if (s_axis_tvalid && s_axis_tlast) begin
      wstate_d = W_IDLE;
    end
  end

  // Write-side state registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      wstate_q  <= W_IDLE;
      wr_ptr_q  <= '0;
      commit_q  <= '0;
      len_acc_q <= '0;
      meta_wr_q <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wr_ptr_q  <= wr_ptr_d;
      commit_q  <= commit_d;
      len_acc_q <= len_acc_d;
      meta_wr_q <= meta_wr_q + (MA+1)'(meta_push);
    end
  end

  // Storage arrays carry no reset; pointers alone define validity.
  always_ff @(posedge axi_aclk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (meta_push) meta_mem[meta_wr_q[MA-1:0]] <= len_new;
  end

  // meta_rd follows words loaded into the output register, meta_pop follows tlast handshakes, so a stalled packet still holds its slot.
  assign rd_word   = mem[rd_ptr_q[AW-1:0]];
  assign can_load  = rd_ptr_q != commit_q;
  assign advance   = ~tvalid_q | m_axis_tready;
  assign head_user = {{(TW-24){1'b0}}, C_SRC_PORT, meta_mem[meta_rd_q[MA-1:0]]};

  // Read FSM: refill the output register whenever it is empty or being accepted.
  always_comb begin
    rstate_d  = rstate_q;
    rd_ptr_d  = rd_ptr_q;
    meta_rd_d = meta_rd_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tstrb_d   = tstrb_q;
    tuser_d   = tuser_q;
    tlast_d   = tlast_q;
    if (advance && can_load) begin
      tvalid_d  = 1'b1;
      {tlast_d, tstrb_d, tdata_d} = rd_word;
      tuser_d   = rstate_q == R_HEAD ? head_user : '0;
      rd_ptr_d  = rd_ptr_q + P_ONE;
      rstate_d  = rd_word[WW-1] ? R_HEAD : R_BODY;
      meta_rd_d = meta_rd_q + (MA+1)'(rd_word[WW-1]);
    end else if (advance) begin
      tvalid_d = 1'b0;
    end
  end

  // Read-side state and output registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      rstate_q   <= R_HEAD;
      rd_ptr_q   <= '0;
      meta_rd_q  <= '0;
      meta_pop_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tstrb_q    <= '0;
      tuser_q    <= '0;
      tlast_q    <= 1'b0;
    end else begin
      rstate_q   <= rstate_d;
      rd_ptr_q   <= rd_ptr_d;
      meta_rd_q  <= meta_rd_d;
      meta_pop_q <= meta_pop_q + (MA+1)'(tvalid_q & m_axis_tready & tlast_q);
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tstrb_q    <= tstrb_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

`ifdef NF10_RX_QUEUE_STATS_EN
  logic [31:0] pkt_cnt_q, drop_cnt_q;

  // Committed and dropped packet counters, free-running with wrap.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_q + 32'(meta_push);
      drop_cnt_q <= drop_cnt_q + 32'(drop);
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_nf10_rx_pkt_queue.sv
// tb_nf10_rx_pkt_queue: scoreboard bench for the rx packet queue
`timescale 1ns/1ps
module tb_nf10_rx_pkt_queue;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int TW = 128;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [TW-1:0] user;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data = '0, m_data, s2_data = '0, m2_data;
  logic [SW-1:0] s_strb = '0, m_strb, s2_strb = '0, m2_strb;
  logic [TW-1:0] s_user = '0, m_user, s2_user = '0, m2_user;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready, m_valid, m_last, m_ready = 1'b1;
  logic s2_valid = 1'b0, s2_last = 1'b0, s2_ready, m2_valid, m2_last, m2_ready = 1'b0;
`ifdef NF10_RX_QUEUE_STATS_EN
  logic [31:0] pkt_cnt, drop_cnt, pkt_cnt2, drop_cnt2;
`endif

  nf10_rx_pkt_queue dut (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(s_data), .s_axis_tstrb(s_strb), .s_axis_tuser(s_user),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
    .m_axis_tdata(m_data), .m_axis_tstrb(m_strb), .m_axis_tuser(m_user),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last)
`ifdef NF10_RX_QUEUE_STATS_EN
    , .pkt_count(pkt_cnt), .drop_count(drop_cnt)
`endif
  );

  nf10_rx_pkt_queue #(.C_DEPTH_LOG2(4)) dut_small (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(s2_data), .s_axis_tstrb(s2_strb), .s_axis_tuser(s2_user),
    .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready), .s_axis_tlast(s2_last),
    .m_axis_tdata(m2_data), .m_axis_tstrb(m2_strb), .m_axis_tuser(m2_user),
    .m_axis_tvalid(m2_valid), .m_axis_tready(m2_ready), .m_axis_tlast(m2_last)
`ifdef NF10_RX_QUEUE_STATS_EN
    , .pkt_count(pkt_cnt2), .drop_count(drop_cnt2)
`endif
  );

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  bit   done = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one packet (full strobes except the last word) and queues its expected output.
  task automatic send_pkt(input int n, input logic [SW-1:0] last_strb, input bit keep);
    exp_t pk[$];
    exp_t e;
    int   len;
    len = 0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) e.data[j*32 +: 32] = $urandom;
      e.strb = (i == n - 1) ? last_strb : '1;
      e.last = (i == n - 1);
      e.user = '0;
      len += $countones(e.strb);
      pk.push_back(e);
      s_data = e.data; s_strb = e.strb; s_last = e.last; s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    pk[0].user = TW'({8'h01, 16'(len > 65535 ? 65535 : len)});
    if (keep) foreach (pk[k]) sb.push_back(pk[k]);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 256'(sb.size()), 0);
  endtask

  task automatic send_small(input int tag, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      s2_data = 256'(tag * 1000 + i); s2_strb = '1; s2_last = (i == n - 1); s2_valid = 1'b1;
      @(posedge clk); #1;
    end
    s2_valid = 1'b0; s2_last = 1'b0;
  endtask

  task automatic collect_small(input int tag, input int n);
    int got;
    got = 0;
    @(posedge clk); #1 m2_ready = 1'b1;
    repeat (3 * n + 10) begin
      @(negedge clk);
      if (m2_valid && m2_ready) begin
        check("small_data", m2_data, 256'(tag * 1000 + got));
        if (got == 0) check("small_len", m2_user, 256'({8'h01, 16'(n * 32)}));
        check("small_last", m2_last, got == n - 1);
        got++;
      end
    end
    check("small_count", 256'(got), 256'(n));
    @(posedge clk); #1 m2_ready = 1'b0;
  endtask

  logic          stall_q = 1'b0;
  logic [DW-1:0] pd;
  logic [TW-1:0] pu;
  logic          pl;

  // Output monitor: scoreboard compare on every handshake, hold check while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, pd);
        check("hold_user", m_user, pu);
        check("hold_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("unexpected_word", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_data", m_data, e.data);
          check("out_strb", m_strb, e.strb);
          check("out_user", m_user, e.user);
          check("out_last", m_last, e.last);
        end
      end
      stall_q = m_valid && !m_ready;
      pd = m_data; pu = m_user; pl = m_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SW-1:0] ls;
    bit            seen;
    int            n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_valid, 0);
    check("rst_tlast", m_last, 0);
    check("rst_tdata", m_data, 0);
    check("rst_tuser", m_user, 0);
    check("rst_tready", s_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", s_ready, 1);

    send_pkt(3, 32'h0000000F, 1);
    @(negedge clk); check("lat1_t1", m_valid, 0);
    @(negedge clk); check("lat1_t2", m_valid, 1);
    wait_drain(50);

    send_pkt(1, 32'h00000001, 1);
    @(negedge clk); check("lat2_t1", m_valid, 0);
    @(negedge clk); check("lat2_t2", m_valid, 1);
    check("single_last", m_last, 1);
    wait_drain(50);

    m_ready = 1'b0;
    send_pkt(2, '1, 1);
    send_pkt(3, 32'h000000FF, 1);
    send_pkt(1, 32'h00000003, 1);
    @(posedge clk); #1 m_ready = 1'b1;
    repeat (6) begin
      @(negedge clk); check("no_gap", m_valid, 1);
    end
    wait_drain(50);

    send_small(1, 10);
    send_small(2, 8);
    collect_small(1, 10);
    send_small(3, 16);
    collect_small(3, 16);
    send_small(4, 17);
    collect_small(4, 0);
`ifdef NF10_RX_QUEUE_STATS_EN
    check("small_pkt_count", pkt_cnt2, 2);
    check("small_drop_count", drop_cnt2, 2);
`endif

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; m_ready = 1'b0;
    for (int k = 0; k < 33; k++) send_pkt(1, 32'h00000001, k < 32);
`ifdef NF10_RX_QUEUE_STATS_EN
    check("meta_pkt_count", pkt_cnt, 32);
    check("meta_drop_count", drop_cnt, 1);
`endif
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain(200);

    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 256'd1; s_strb = '1; s_last = 1'b0;
    @(posedge clk); #1;
    s_data = 256'd2; rst = 1'b1;
    @(negedge clk); check("midpkt_rst_tready", s_ready, 0);
    @(posedge clk); #1 rst = 1'b0; s_valid = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk); if (m_valid) seen = 1'b1;
    end
    check("midpkt_no_output", seen, 0);
    send_pkt(2, 32'h0000FFFF, 1);
    wait_drain(50);

    fork
      begin
        for (int p = 0; p < 100; p++) begin
          n = $urandom_range(1, 20);
          ls = '1;
          ls = ls >> (32 - $urandom_range(1, 32));
          send_pkt(n, ls, 1);
          repeat (2 * n + 4) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
